// File: rtl/module_control_wb.sv
// Wishbone-style control block that forwards single requests to one of N downstream modules.
// It enforces a wait timeout and exposes sticky error status on select 0.
module module_control_wb #(
    parameter int N_MODULES = 4,
    parameter int SEL_W     = 3,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          cyc_i,
    input  logic                          stb_i,
    input  logic                          we_i,
    input  logic [SEL_W-1:0]              sel_i,
    input  logic [DATA_W-1:0]             data_i,
    output logic                          ack_o,
    output logic [DATA_W-1:0]             data_o,
    output logic [N_MODULES-1:0]          module_stb_o,
    output logic [N_MODULES-1:0]          module_we_o,
    output logic [DATA_W-1:0]             module_wdata_o,
    input  logic [N_MODULES*DATA_W-1:0]   module_data_i,
    input  logic [N_MODULES-1:0]          module_ack_i
);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t               state, state_nxt;
    logic [SEL_W-1:0]     sel_q, sel_d, last_sel, last_sel_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic                 err_timeout, err_unmapped;
    logic                 set_to, set_un, clr_to, clr_un;
    logic [DATA_W-1:0]    resp_q, resp_d, data_d, wdata_d;
    logic [DATA_W-1:0]    ack_data, status_word;
    logic [N_MODULES-1:0] stb_d, we_d;
    logic                 ack_d;
    logic                 req, is_status, mapped, ack_hit, timed_out;

    assign req       = cyc_i & stb_i;
    assign is_status = (sel_i == '0);
    assign mapped    = !is_status && (sel_i <= SEL_W'(N_MODULES));
    // The strobe vector is one-hot on the selected module, so it masks out foreign acks.
    assign ack_hit   = |(module_ack_i & module_stb_o);
    assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        ack_data = '0;
        for (int k = 0; k < N_MODULES; k++) begin
            if (module_stb_o[k]) ack_data = module_data_i[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        status_word                = '0;
        status_word[0]             = err_timeout;
        status_word[1]             = err_unmapped;
        status_word[SEL_W+1:2]     = last_sel;
        status_word[23:16]         = 8'(N_MODULES);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= S_IDLE;
            sel_q          <= '0;
            last_sel       <= '0;
            cnt            <= '0;
            err_timeout    <= 1'b0;
            err_unmapped   <= 1'b0;
            resp_q         <= '0;
            ack_o          <= 1'b0;
            data_o         <= '0;
            module_stb_o   <= '0;
            module_we_o    <= '0;
            module_wdata_o <= '0;
        end else begin
            state          <= state_nxt;
            sel_q          <= sel_d;
            last_sel       <= last_sel_d;
            cnt            <= cnt_d;
            // A set in the same cycle as a W1C clear wins.
            err_timeout    <= (err_timeout  & ~clr_to) | set_to;
            err_unmapped   <= (err_unmapped & ~clr_un) | set_un;
            resp_q         <= resp_d;
            ack_o          <= ack_d;
            data_o         <= data_d;
            module_stb_o   <= stb_d;
            module_we_o    <= we_d;
            module_wdata_o <= wdata_d;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req) state_nxt = mapped ? S_WAIT : S_RESP;
            S_WAIT: begin
                if (!cyc_i)                    state_nxt = S_IDLE;
                else if (ack_hit || timed_out) state_nxt = S_RESP;
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        sel_d      = sel_q;
        last_sel_d = last_sel;
        cnt_d      = cnt;
        resp_d     = resp_q;
        wdata_d    = module_wdata_o;
        stb_d      = module_stb_o;
        we_d       = module_we_o;
        ack_d      = 1'b0;
        data_d     = '0;
        set_to     = 1'b0;
        set_un     = 1'b0;
        clr_to     = 1'b0;
        clr_un     = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    sel_d   = sel_i;
                    wdata_d = data_i;
                    cnt_d   = '0;
                    resp_d  = '0;
                    if (mapped) begin
                        for (int k = 0; k < N_MODULES; k++) begin
                            if (sel_i == SEL_W'(k + 1)) begin
                                stb_d[k] = 1'b1;
                                we_d[k]  = we_i;
                            end
                        end
                    end else if (is_status) begin
                        if (we_i) begin
                            clr_to = data_i[0];
                            clr_un = data_i[1];
                        end else begin
                            resp_d = status_word;
                        end
                    end else begin
                        set_un     = 1'b1;
                        last_sel_d = sel_i;
                    end
                end
            end
            S_WAIT: begin
                if (!cyc_i) begin
                    stb_d = '0;
                    we_d  = '0;
                end else if (ack_hit) begin
                    resp_d = ack_data;
                    stb_d  = '0;
                    we_d   = '0;
                end else if (timed_out) begin
                    resp_d     = '0;
                    stb_d      = '0;
                    we_d       = '0;
                    set_to     = 1'b1;
                    last_sel_d = sel_q;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_RESP: begin
                ack_d  = 1'b1;
                data_d = resp_q;
            end
            default: ;
        endcase
    end
endmodule
